// File: rtl/cache_tag_nway_pkg.sv
// rtl/cache_tag_nway_pkg.sv - shared types and width helpers for the cache tag stores
package cache_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

    function automatic int tag_w(input int msb, input int lsb);
        return msb - lsb + 1;
    endfunction

    function automatic int way_w(input int ways);
        return (ways <= 1) ? 1 : clog2(ways);
    endfunction

    // A 1-way store has no tree; keep one dummy bit so vectors stay legal.
    function automatic int plru_w(input int ways);
        return (ways <= 1) ? 1 : ways - 1;
    endfunction

endpackage

// File: rtl/cache_tag_nway_plru_tree.sv
// rtl/cache_tag_nway_plru_tree.sv - combinational tree-PLRU next-state and victim logic
module plru_tree
    import cache_pkg::*;
#(
    parameter int WAYS = 2,
    localparam int WAY_W = way_w(WAYS),
    localparam int PLRU_W = plru_w(WAYS),
    localparam int LEVELS = clog2(WAYS)
) (
    input  logic [PLRU_W-1:0] plru_bits,
    input  logic [WAY_W-1:0]  acc_way,
    output logic [PLRU_W-1:0] plru_next,
    output logic [WAY_W-1:0]  victim
);

    // Nodes are heap-numbered from 1 (root); node n lives in bit n-1.
    logic [31:0] cur32;
    logic [31:0] acc32;
    logic [31:0] nxt32;
    int          node_v;
    int          node_u;

    assign cur32 = 32'(plru_bits);
    assign acc32 = 32'(acc_way);

    // Follow the node bits (each points at the LRU half) down to a leaf.
    always_comb begin
        node_v = 1;
        for (int l = 0; l < LEVELS; l++) begin
            node_v = 2 * node_v + int'(cur32[5'(node_v - 1)]);
        end
        victim = WAY_W'(node_v - WAYS);
    end

    // Walk the accessed way's path, pointing each node at the other half.
    always_comb begin
        nxt32  = cur32;
        node_u = 1;
        for (int l = 0; l < LEVELS; l++) begin
            nxt32[5'(node_u - 1)] = ~acc32[5'(LEVELS - 1 - l)];
            node_u = 2 * node_u + int'(acc32[5'(LEVELS - 1 - l)]);
        end
        plru_next = nxt32[PLRU_W-1:0];
    end

endmodule

// File: rtl/cache_tag_nway.sv
// rtl/cache_tag_nway.sv - N-way set-associative tag store with PLRU and invalidate sweep
module cache_tag_nway
    import cache_pkg::*;
#(
    parameter int TAGMSB = 31,
    parameter int TAGLSB = 14,
    parameter int INDEX_BITS = 10,
    parameter int WAYS = 2,
    localparam int TAG_W = tag_w(TAGMSB, TAGLSB),
    localparam int WAY_W = way_w(WAYS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [INDEX_BITS-1:0] req_index,
    input  logic [TAG_W-1:0]      req_tag,
    output logic                  lkp_valid,
    output logic                  lkp_hit,
    output logic [WAY_W-1:0]      lkp_way,
    output logic                  lkp_dirty,
    output logic [WAY_W-1:0]      vic_way,
    output logic                  vic_valid,
    output logic                  vic_dirty,
    output logic [TAG_W-1:0]      vic_tag,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [WAY_W-1:0]      wr_way,
    input  logic                  wr_valid,
    input  logic                  wr_dirty,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic                  inv_all,
    output logic                  busy
);

    localparam int SETS = 2 ** INDEX_BITS;
    localparam int PLRU_W = plru_w(WAYS);

    state_t                  state;
    state_t                  state_next;
    logic [INDEX_BITS-1:0]   sweep_cnt;

    logic [TAG_W-1:0]        tag_mem   [SETS][WAYS];
    logic [WAYS-1:0]         valid_mem [SETS];
    logic [WAYS-1:0]         dirty_mem [SETS];
    logic [PLRU_W-1:0]       plru_mem  [SETS];

    logic                    accept;
    logic [WAYS-1:0]         set_valid;
    logic [WAYS-1:0]         set_dirty;
    logic                    hit;
    logic [WAY_W-1:0]        hit_way;
    logic                    has_inv;
    logic [WAY_W-1:0]        inv_way;
    logic [WAY_W-1:0]        plru_vic;
    logic [WAY_W-1:0]        vic_sel;
    logic [PLRU_W-1:0]       plru_hit_next;
    logic [PLRU_W-1:0]       plru_wr_next;
    logic [WAY_W-1:0]        wr_tree_vic;

    // FSM state register; reset always restarts the sweep
    always_ff @(posedge clk) begin
        if (rst) state <= ST_SWEEP;
        else     state <= state_next;
    end

    // Sweep counter: held at zero while idle so every sweep starts at set 0
    always_ff @(posedge clk) begin
        if (rst || state == ST_IDLE) sweep_cnt <= '0;
        else                         sweep_cnt <= sweep_cnt + 1'b1;
    end

    // Next-state: leave the sweep after the last set, enter it on inv_all
    always_comb begin
        state_next = state;
        case (state)
            ST_SWEEP: if (&sweep_cnt) state_next = ST_IDLE;
            ST_IDLE:  if (inv_all)    state_next = ST_SWEEP;
            default:  state_next = ST_SWEEP;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy      = (state == ST_SWEEP);
        req_ready = (state == ST_IDLE);
    end

    assign accept    = req_valid && req_ready;
    assign set_valid = valid_mem[req_index];
    assign set_dirty = dirty_mem[req_index];

    // Tag compare and first-invalid search; descending scan so the lowest way wins
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (set_valid[w] && tag_mem[req_index][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!set_valid[w]) begin
                has_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
        vic_sel = has_inv ? inv_way : plru_vic;
    end

    plru_tree #(.WAYS(WAYS)) u_plru_lkp (
        .plru_bits (plru_mem[req_index]),
        .acc_way   (hit_way),
        .plru_next (plru_hit_next),
        .victim    (plru_vic)
    );

    plru_tree #(.WAYS(WAYS)) u_plru_wr (
        .plru_bits (plru_mem[wr_index]),
        .acc_way   (wr_way),
        .plru_next (plru_wr_next),
        .victim    (wr_tree_vic)
    );

    // Lookup response registers; non-accepted cycles hold the last response
    always_ff @(posedge clk) begin
        if (rst) begin
            lkp_valid <= 1'b0;
            lkp_hit   <= 1'b0;
            lkp_way   <= '0;
            lkp_dirty <= 1'b0;
            vic_way   <= '0;
            vic_valid <= 1'b0;
            vic_dirty <= 1'b0;
            vic_tag   <= '0;
        end else begin
            lkp_valid <= accept;
            if (accept) begin
                lkp_hit   <= hit;
                lkp_way   <= hit_way;
                lkp_dirty <= hit && set_dirty[hit_way];
                vic_way   <= vic_sel;
                vic_valid <= set_valid[vic_sel];
                vic_dirty <= set_dirty[vic_sel];
                vic_tag   <= tag_mem[req_index][vic_sel];
            end
        end
    end

    // Storage update: sweep clears one set per cycle; otherwise hit/write PLRU
    // and the write port. The write's PLRU update is last so it wins on a shared set.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_SWEEP) begin
                valid_mem[sweep_cnt] <= '0;
                dirty_mem[sweep_cnt] <= '0;
                plru_mem[sweep_cnt]  <= '0;
            end else begin
                if (accept && hit) plru_mem[req_index] <= plru_hit_next;
                if (wr_en) begin
                    tag_mem[wr_index][wr_way]   <= wr_tag;
                    valid_mem[wr_index][wr_way] <= wr_valid;
                    dirty_mem[wr_index][wr_way] <= wr_dirty;
                    if (wr_valid) plru_mem[wr_index] <= plru_wr_next;
                end
            end
        end
    end

endmodule

// File: doc/cache_tag_nway.md
Name: cache_tag_nway

Overview:
- Parametrised N-way set-associative tag store for the data cache; successor to the direct-mapped tag array.
- Provides a registered lookup with hit/way detection, pseudo-LRU victim selection, a tag/state write port, and a self-timed invalidate-all sweep that also runs after reset.
- Sits between the cache controller FSM and the data arrays; the controller owns write-back of dirty victims.

Parameters:
- TAGMSB, 31, MSB of address tag field
- TAGLSB, 14, LSB of address tag field; TAG_W = TAGMSB-TAGLSB+1
- INDEX_BITS, 10, set index width; SETS = 2**INDEX_BITS
- WAYS, 2, associativity; must be a power of two, 1..8; WAY_W = max(1, clog2(WAYS))

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  lookup request
- req_ready  out  1  lookup accepted when high; low while busy
- req_index  in  INDEX_BITS  set to look up
- req_tag  in  TAG_W  tag to compare
- lkp_valid  out  1  lookup response valid; one cycle after acceptance
- lkp_hit  out  1  a valid way matched req_tag
- lkp_way  out  WAY_W  matching way (0 on miss)
- lkp_dirty  out  1  dirty bit of matching way (0 on miss)
- vic_way  out  WAY_W  way to replace
- vic_valid  out  1  valid bit of victim way
- vic_dirty  out  1  dirty bit of victim way
- vic_tag  out  TAG_W  tag of victim way (write-back address)
- wr_en  in  1  write one way's tag/state
- wr_index  in  INDEX_BITS  set to write
- wr_way  in  WAY_W  way to write
- wr_valid, wr_dirty  in  1 each  new state bits
- wr_tag  in  TAG_W  new tag
- inv_all  in  1  start invalidate-all sweep (pulse)
- busy  out  1  sweep in progress

Behaviour:
- Storage per set: WAYS entries of {valid, dirty, tag} plus WAYS-1 tree-PLRU bits. Contents are not cleared by reset; the sweep clears them.
- FSM states are SWEEP and IDLE. rst forces SWEEP with sweep counter = 0 from any state, including mid-sweep.
- In SWEEP, each cycle writes valid=0, dirty=0, PLRU=0 to all ways of set[counter], then increments the counter. After set SETS-1, the FSM goes to IDLE, so a sweep lasts exactly SETS cycles.
- In IDLE, inv_all moves to SWEEP with counter = 0. inv_all is ignored while already in SWEEP.
- busy = (state == SWEEP). req_ready = !busy. During SWEEP, wr_en and unaccepted requests are ignored.
- Reset values: lkp_valid=0, lkp_hit=0, lkp_way=0, lkp_dirty=0, vic_*=0, busy=1, req_ready=0.
- Lookup latency is 1 cycle. When req_valid && req_ready at edge N, the lkp_* and vic_* outputs are valid in cycle N+1 with lkp_valid=1. Otherwise lkp_valid=0 and the other outputs hold their last values.
- Hit: exactly one valid way has a tag equal to req_tag. Multiple matches are a controller bug; the lowest-numbered way is reported.
- Victim selection: the lowest-numbered invalid way if one exists, else the way the PLRU tree points to.
- PLRU update, applied at the edge:
  - An accepted lookup that hits makes lkp_way MRU.
  - wr_en with wr_valid=1 makes wr_way MRU.
  - wr_en with wr_valid=0 leaves PLRU unchanged.
  - When a write and a hit target the same set in the same cycle, the write's update wins.
- Tree PLRU convention: each node bit points to the LRU subtree (0 = lower half). An access sets every node on its path to point away from it.
- Same-cycle write and lookup to the same set: the lookup returns pre-write contents (read-before-write). No forwarding.

Decomposition:
- Shared package cache_pkg holds:
  - TAG_W and WAY_W derivation functions
  - clog2
  - FSM state encoding (ST_IDLE, ST_SWEEP)
- Sub-module plru_tree (parameter WAYS) is purely combinational:
  - next PLRU bits from current bits and accessed way
  - victim way from current bits
  - reused by the future I-cache tag store

Test Plan (INDEX_BITS=4, WAYS=4, default tags):
1. Release rst -> busy=1 and req_ready=0 for exactly 16 cycles, then 0/1. A lookup of any set gives lkp_hit=0, vic_way=0, vic_valid=0.
2. Write idx 3, way 2, tag 0x1234, valid=1, dirty=1; then look up idx 3 tag 0x1234 -> next cycle lkp_valid=1, lkp_hit=1, lkp_way=2, lkp_dirty=1.
3. Write ways 0,1,2,3 of idx 5 in order (valid), then hit-lookup way 0 -> a subsequent lookup gives vic_way=2, vic_valid=1, vic_tag equal to way 2's tag.
4. Fill idx 7 way 1 (dirty), then pulse inv_all -> busy=1 for 16 cycles. Then lookup idx 7 gives lkp_hit=0, vic_way=0, vic_valid=0, vic_dirty=0.
5. In the same cycle, wr_en to idx 9 way 0 tag 0xAA and accepted lookup idx 9 tag 0xAA -> response lkp_hit=0. A lookup one cycle later gives lkp_hit=1, lkp_way=0.
6. Assert rst for 1 cycle when the sweep counter=7 -> the sweep restarts at 0. busy stays high for 16 further cycles, and wr_en during that window has no effect.
